// File: rtl/ppu_mc_core.sv
// Multi-cycle accumulator core with a req/ack word bus, carry flag, conditional jumps and sticky HALT.
// Optional immediate ops (LOADI/ADDI) are enabled by defining PPU_IMMEDIATE_EN.
module ppu_mc_core #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  halted,
  output logic                  carry_out,
  output logic [ADDR_WIDTH-1:0] program_counter_out,
  output logic [DATA_WIDTH-1:0] register_AC_out,
  output logic [DATA_WIDTH-1:0] memory_data_register_out,
  output logic [ADDR_WIDTH-1:0] memory_addr_register_out,
  output logic [DATA_WIDTH-1:0] instruction_register_out
);
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  if (DATA_WIDTH < ADDR_WIDTH + 4) begin : g_width_chk
    $error("ppu_mc_core: DATA_WIDTH must be >= ADDR_WIDTH+4");
  end

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_JUMP  = 4'h3;
  localparam logic [3:0] OP_JNEG  = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_JZERO = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h8;
  localparam logic [3:0] OP_SHR   = 4'h9;
  localparam logic [3:0] OP_LOADI = 4'hA;
  localparam logic [3:0] OP_ADDI  = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q, mar_q;
  logic [DW-1:0] ac_q, mdr_q, ir_q;
  logic          carry_q, halted_q;

  logic [3:0]    opc;
  logic [AW-1:0] arg;
  logic          exec_mem;
  logic [DW:0]   add_r, sub_r;

  function automatic logic is_mem(input logic [3:0] op);
    return op inside {OP_ADD, OP_STORE, OP_LOAD, OP_SUB, OP_AND};
  endfunction

  assign opc      = ir_q[DW-1 -: 4];
  assign arg      = ir_q[AW-1:0];
  assign exec_mem = (state_q == S_EXEC) && is_mem(opc);
  assign add_r    = {1'b0, ac_q} + {1'b0, mem_rdata};
  // carry out of AC + ~M + 1 is the no-borrow flag
  assign sub_r    = {1'b0, ac_q} + {1'b0, ~mem_rdata} + {{DW{1'b0}}, 1'b1};

`ifdef PPU_IMMEDIATE_EN
  logic [DW-1:0] imm;
  logic [DW:0]   addi_r;
  assign imm    = {{(DW-AW){1'b0}}, arg};
  assign addi_r = {1'b0, ac_q} + {1'b0, imm};
`endif

  // Request is decoded from state so a fetch can be acked in its first cycle;
  // reset masks it at once so an in-flight transfer is abandoned.
  assign mem_req   = !rst && ((state_q == S_FETCH) || exec_mem);
  assign mem_we    = (state_q == S_EXEC) && (opc == OP_STORE);
  assign mem_addr  = mar_q;
  assign mem_wdata = ac_q;

  assign halted                   = halted_q;
  assign carry_out                = carry_q;
  assign program_counter_out      = pc_q;
  assign register_AC_out          = ac_q;
  assign memory_data_register_out = mdr_q;
  assign memory_addr_register_out = mar_q;
  assign instruction_register_out = ir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      mar_q    <= '0;
      ac_q     <= '0;
      mdr_q    <= '0;
      ir_q     <= '0;
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ack) begin
            mdr_q   <= mem_rdata;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          ir_q    <= mdr_q;
          pc_q    <= pc_q + AW'(1);
          if (is_mem(mdr_q[DW-1 -: 4])) mar_q <= mdr_q[AW-1:0];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_mem(opc)) begin
            if (mem_ack) begin
              if (opc != OP_STORE) mdr_q <= mem_rdata;
              case (opc)
                OP_ADD:  {carry_q, ac_q} <= add_r;
                OP_SUB: begin
                  ac_q    <= sub_r[DW-1:0];
                  carry_q <= sub_r[DW];
                end
                OP_LOAD: ac_q <= mem_rdata;
                OP_AND:  ac_q <= ac_q & mem_rdata;
                default: ;
              endcase
              mar_q   <= pc_q;
              state_q <= S_FETCH;
            end
          end else begin
            // MAR tracks the next fetch address; jumps override it below
            mar_q   <= pc_q;
            state_q <= S_FETCH;
            case (opc)
              OP_JUMP: begin
                pc_q  <= arg;
                mar_q <= arg;
              end
              OP_JNEG: begin
                if (ac_q[DW-1]) begin
                  pc_q  <= arg;
                  mar_q <= arg;
                end
              end
              OP_JZERO: begin
                if (ac_q == '0) begin
                  pc_q  <= arg;
                  mar_q <= arg;
                end
              end
              OP_SHL: begin
                ac_q    <= {ac_q[DW-2:0], 1'b0};
                carry_q <= ac_q[DW-1];
              end
              OP_SHR: begin
                ac_q    <= {ac_q[DW-1], ac_q[DW-1:1]};
                carry_q <= ac_q[0];
              end
              OP_HALT: begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
              end
`ifdef PPU_IMMEDIATE_EN
              OP_LOADI: ac_q <= imm;
              OP_ADDI:  {carry_q, ac_q} <= addi_r;
`endif
              default: ;
            endcase
          end
        end
        S_HALT: ;
        default: state_q <= S_FETCH;
      endcase
    end
  end
endmodule
